// File: rtl/coin_meter_sequencer_if.sv
// Bundles the coin/lockout request inputs and the counter/lockout latch write port.
// The master drives requests and observes the latch port; the slave is the sequencer.
interface coin_meter_sequencer_if #(
  parameter int PEND_W = 4
);
  logic              COIN_REQ1;
  logic              COIN_REQ2;
  logic              LOCK_REQ1;
  logic              LOCK_REQ2;
  logic              nCOUNTOUT;
  logic [2:0]        ADDR;
  logic              ADDR_7;
  logic [PEND_W-1:0] PEND1;
  logic [PEND_W-1:0] PEND2;
  logic [1:0]        OVF;
  logic              BUSY;

  modport master (
    output COIN_REQ1, COIN_REQ2, LOCK_REQ1, LOCK_REQ2,
    input  nCOUNTOUT, ADDR, ADDR_7, PEND1, PEND2, OVF, BUSY
  );

  modport slave (
    input  COIN_REQ1, COIN_REQ2, LOCK_REQ1, LOCK_REQ2,
    output nCOUNTOUT, ADDR, ADDR_7, PEND1, PEND2, OVF, BUSY
  );
endinterface

// File: rtl/coin_meter_sequencer.sv
// Queues coin counts and lockout changes for two channels and serialises them onto one latch write port.
// Coin request to strobe is 2 cycles on an idle bus; requests wait while the bus is busy, counts saturate.
module coin_meter_sequencer #(
  parameter int STROBE_W  = 2,
  parameter int ON_TICKS  = 2000,
  parameter int OFF_TICKS = 2000,
  parameter int PEND_W    = 4,
  parameter int TICK_W    = 16
) (
  input logic                   CLK,
  input logic                   nRESET,
  coin_meter_sequencer_if.slave bus
);

  localparam int SCNT_W = (STROBE_W < 2) ? 1 : $clog2(STROBE_W + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic [2:0] {
    CH_IDLE,
    CH_NEED_ON,
    CH_ON,
    CH_NEED_OFF,
    CH_OFF
  } ch_state_t;

  typedef enum logic [1:0] {
    B_IDLE,
    B_SETUP,
    B_STROBE,
    B_HOLD
  } bus_state_t;

  typedef enum logic [2:0] {
    G_LOCK1,
    G_LOCK2,
    G_OFF1,
    G_OFF2,
    G_ON1,
    G_ON2
  } gnt_t;

  logic [1:0] coin;
  logic [1:0] lock_lvl;

  ch_state_t         ch_q   [2];
  ch_state_t         ch_d   [2];
  logic [TICK_W-1:0] tmr_q  [2];
  logic [TICK_W-1:0] tmr_d  [2];
  logic [PEND_W-1:0] pend_q [2];
  logic [PEND_W-1:0] pend_d [2];
  logic [1:0]        ovf_q, ovf_d;
  logic [1:0]        shadow_q, shadow_d;

  logic [1:0] req_on, req_off, req_lock;
  logic [1:0] on_done, off_done, lock_done;
  logic       bus_done;

  bus_state_t        bst_q, bst_d;
  gnt_t              gnt_q, gnt_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic              rr_q, rr_d;
  logic              ncount_q, ncount_d;
  logic [2:0]        addr_q, addr_d;
  logic              dat_q, dat_d;
  logic              busy_q, busy_d;

  assign coin     = {bus.COIN_REQ2, bus.COIN_REQ1};
  assign lock_lvl = {bus.LOCK_REQ2, bus.LOCK_REQ1};

  // Completion reaches the granted requester on the edge that leaves B_HOLD.
  assign bus_done  = (bst_q == B_HOLD);
  assign on_done   = {bus_done && (gnt_q == G_ON2),   bus_done && (gnt_q == G_ON1)};
  assign off_done  = {bus_done && (gnt_q == G_OFF2),  bus_done && (gnt_q == G_OFF1)};
  assign lock_done = {bus_done && (gnt_q == G_LOCK2), bus_done && (gnt_q == G_LOCK1)};

  always_comb begin : ch_comb
    ovf_d    = ovf_q;
    shadow_d = shadow_q;
    req_on   = '0;
    req_off  = '0;
    req_lock = '0;
    for (int i = 0; i < 2; i++) begin
      ch_d[i]   = ch_q[i];
      tmr_d[i]  = tmr_q[i];
      pend_d[i] = pend_q[i];

      // Requests also assert in the cycle before the state would advance, so an
      // idle bus grants on the same edge the channel reaches its NEED state.
      req_lock[i] = (shadow_q[i] != lock_lvl[i]);
      req_off[i]  = (ch_q[i] == CH_NEED_OFF) || ((ch_q[i] == CH_ON) && (tmr_q[i] == '0));
      req_on[i]   = (ch_q[i] == CH_NEED_ON) ||
                    ((pend_q[i] != '0) &&
                     ((ch_q[i] == CH_IDLE) || ((ch_q[i] == CH_OFF) && (tmr_q[i] == '0))));

      if (lock_done[i]) begin
        shadow_d[i] = dat_q;
      end

      if (coin[i] && !on_done[i]) begin
        if (pend_q[i] == PEND_MAX) begin
          ovf_d[i] = 1'b1;
        end else begin
          pend_d[i] = pend_q[i] + PEND_W'(1);
        end
      end else if (on_done[i] && !coin[i]) begin
        pend_d[i] = pend_q[i] - PEND_W'(1);
      end

      case (ch_q[i])
        CH_IDLE: begin
          if (pend_q[i] != '0) begin
            ch_d[i] = CH_NEED_ON;
          end
        end
        CH_NEED_ON: begin
          if (on_done[i]) begin
            ch_d[i]  = CH_ON;
            tmr_d[i] = TICK_W'(ON_TICKS);
          end
        end
        CH_ON: begin
          if (tmr_q[i] == '0) begin
            ch_d[i] = CH_NEED_OFF;
          end else begin
            tmr_d[i] = tmr_q[i] - TICK_W'(1);
          end
        end
        CH_NEED_OFF: begin
          if (off_done[i]) begin
            ch_d[i]  = CH_OFF;
            tmr_d[i] = TICK_W'(OFF_TICKS);
          end
        end
        CH_OFF: begin
          if (tmr_q[i] == '0) begin
            ch_d[i] = CH_IDLE;
          end else begin
            tmr_d[i] = tmr_q[i] - TICK_W'(1);
          end
        end
        default: ch_d[i] = CH_IDLE;
      endcase
    end
  end

  always_comb begin : bus_comb
    bst_d  = bst_q;
    gnt_d  = gnt_q;
    scnt_d = scnt_q;
    rr_d   = rr_q;
    addr_d = addr_q;
    dat_d  = dat_q;

    case (bst_q)
      B_IDLE: begin
        if ((|req_lock) || (|req_off) || (|req_on)) begin
          bst_d = B_SETUP;
          if (req_lock[0]) begin
            gnt_d  = G_LOCK1;
            addr_d = 3'b010;
            dat_d  = lock_lvl[0];
          end else if (req_lock[1]) begin
            gnt_d  = G_LOCK2;
            addr_d = 3'b011;
            dat_d  = lock_lvl[1];
          end else if (req_off[0]) begin
            gnt_d  = G_OFF1;
            addr_d = 3'b000;
            dat_d  = 1'b0;
          end else if (req_off[1]) begin
            gnt_d  = G_OFF2;
            addr_d = 3'b001;
            dat_d  = 1'b0;
          end else if (req_on[0] && (!req_on[1] || !rr_q)) begin
            gnt_d  = G_ON1;
            addr_d = 3'b000;
            dat_d  = 1'b1;
            rr_d   = 1'b1;
          end else begin
            gnt_d  = G_ON2;
            addr_d = 3'b001;
            dat_d  = 1'b1;
            rr_d   = 1'b0;
          end
        end
      end
      B_SETUP: begin
        bst_d  = B_STROBE;
        scnt_d = SCNT_W'(STROBE_W - 1);
      end
      B_STROBE: begin
        if (scnt_q == '0) begin
          bst_d = B_HOLD;
        end else begin
          scnt_d = scnt_q - SCNT_W'(1);
        end
      end
      B_HOLD:  bst_d = B_IDLE;
      default: bst_d = B_IDLE;
    endcase

    ncount_d = (bst_d != B_STROBE);
    busy_d   = (bst_d != B_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      for (int i = 0; i < 2; i++) begin
        ch_q[i]   <= CH_IDLE;
        tmr_q[i]  <= '0;
        pend_q[i] <= '0;
      end
      ovf_q    <= '0;
      shadow_q <= '0;
      bst_q    <= B_IDLE;
      gnt_q    <= G_LOCK1;
      scnt_q   <= '0;
      rr_q     <= 1'b0;
      ncount_q <= 1'b1;
      addr_q   <= 3'b000;
      dat_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        ch_q[i]   <= ch_d[i];
        tmr_q[i]  <= tmr_d[i];
        pend_q[i] <= pend_d[i];
      end
      ovf_q    <= ovf_d;
      shadow_q <= shadow_d;
      bst_q    <= bst_d;
      gnt_q    <= gnt_d;
      scnt_q   <= scnt_d;
      rr_q     <= rr_d;
      ncount_q <= ncount_d;
      addr_q   <= addr_d;
      dat_q    <= dat_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.nCOUNTOUT = ncount_q;
  assign bus.ADDR      = addr_q;
  assign bus.ADDR_7    = dat_q;
  assign bus.PEND1     = pend_q[0];
  assign bus.PEND2     = pend_q[1];
  assign bus.OVF       = ovf_q;
  assign bus.BUSY      = busy_q;

endmodule

// File: doc/coin_meter_sequencer.md
Name: coin_meter_sequencer

Overview:
- Sequences writes to the I/O latch that drives the coin counters and coin lockouts.
- Accepts coin-count events and lockout requests from two channels and queues pending counts per channel.
- Produces timed meter on/off pulses and arbitrates all requests onto one latch write port (nCOUNTOUT, A3..A1, A7).
- Sits between the system/coin logic and the counter/lockout latch, in the CLK domain.

Parameters:
- STROBE_W, 2: cycles nCOUNTOUT is held low per write (≥1).
- ON_TICKS, 2000: CLK cycles a meter stays energised per count.
- OFF_TICKS, 2000: CLK cycles a meter stays off before its next count.
- PEND_W, 4: width of the per-channel pending-count register.
- TICK_W, 16: width of the per-channel timers.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- nRESET  in  1  reset, synchronous, active-low.
- COIN_REQ1  in  1  one-cycle pulse: add one count to meter 1.
- COIN_REQ2  in  1  one-cycle pulse: add one count to meter 2.
- LOCK_REQ1  in  1  desired level of lockout 1.
- LOCK_REQ2  in  1  desired level of lockout 2.
- nCOUNTOUT  out  1  latch write strobe, active-low.
- ADDR  out  3  latch select, A3..A1: 000 counter1, 001 counter2, 010 lockout1, 011 lockout2.
- ADDR_7  out  1  latch data bit.
- PEND1  out  PEND_W  pending counts, meter 1.
- PEND2  out  PEND_W  pending counts, meter 2.
- OVF  out  2  sticky saturation flags, bit0 = channel 1.
- BUSY  out  1  high whenever the bus FSM is not in B_IDLE.

Behaviour:
- Reset (nRESET low at an edge):
  - nCOUNTOUT=1, ADDR=000, ADDR_7=0, PEND1/PEND2=0, OVF=00, BUSY=0.
  - Lockout shadows=0, both channels in CH_IDLE, bus FSM in B_IDLE, round-robin pointer = channel 1.
  - Reset mid-write ends the strobe at that edge, with nCOUNTOUT high next cycle. In-flight pulses and pending counts are discarded.
  - Shadows reset to 0 to match the latch's own reset state.
- Pending count:
  - COIN_REQn increments PENDn, saturating at 2^PEND_W-1.
  - A request arriving while PENDn is saturated sets OVF[n-1]; OVF clears only on reset.
  - PENDn decrements when that channel's ON write completes.
  - Increment and decrement in the same cycle leave PENDn unchanged.
- Channel FSM, per channel:
  - CH_IDLE: if PEND≠0, go to CH_NEED_ON.
  - CH_NEED_ON: requests a write with data 1; on completion go to CH_ON and load the timer with ON_TICKS.
  - CH_ON: decrement the timer each cycle; at 0 go to CH_NEED_OFF.
  - CH_NEED_OFF: requests a write with data 0; on completion go to CH_OFF and load OFF_TICKS.
  - CH_OFF: count down; at 0 go to CH_IDLE.
- Lockout: when shadow ≠ LOCK_REQn, request a write of LOCK_REQn to the lockout address. The shadow updates at completion and is then re-compared, so a toggle during the write causes a second write.
- Arbitration (sampled only in B_IDLE), priority order:
  1. Lockout 1
  2. Lockout 2
  3. Counter-OFF writes, channel 1 before channel 2
  4. Counter-ON writes, round-robin: the pointer flips to the other channel after each ON grant.
- Bus FSM:
  - B_IDLE → B_SETUP (1 cycle): ADDR/ADDR_7 driven, nCOUNTOUT=1.
  - B_SETUP → B_STROBE (STROBE_W cycles): nCOUNTOUT=0.
  - B_STROBE → B_HOLD (1 cycle): nCOUNTOUT=1, ADDR/ADDR_7 still held.
  - B_HOLD → B_IDLE; completion is signalled to the granted requester on exit from B_HOLD.
  - ADDR/ADDR_7 are stable from SETUP through HOLD and hold their last value while idle.
  - Back-to-back grants are allowed: at least 1 idle cycle separates writes.
- Latency:
  - COIN_REQ at edge k gives SETUP at k+1 and nCOUNTOUT falling at k+2, if the bus is idle.
  - ON-write strobe start to OFF-write strobe start = ON_TICKS+STROBE_W+3 cycles, absent contention.
  - OFF-write strobe start to the next ON-write strobe start = OFF_TICKS+STROBE_W+3 cycles.
- Registered outputs only; no combinational path from inputs to nCOUNTOUT/ADDR/ADDR_7.

Test Plan:
- Single coin (STROBE_W=2, ON=OFF=10): COIN_REQ1 pulse.
  - ADDR=000, ADDR_7=1; nCOUNTOUT low 2 cycles starting 2 cycles after the request.
  - PEND1 goes 1→0 at HOLD exit.
  - Second strobe with ADDR_7=0 falls 15 cycles after the first.
- Burst: 3 COIN_REQ1 pulses on consecutive cycles.
  - PEND1 reaches 3.
  - Six writes alternate ADDR_7=1/0; strobe falls spaced 15 cycles apart.
  - PEND1=0 at end; OVF=00.
- Contention: COIN_REQ1 and COIN_REQ2 on the same cycle, with LOCK_REQ2 rising the same cycle.
  - First write is ADDR=011 data 1.
  - Then ADDR=000 data 1, then ADDR=001 data 1.
  - OFF writes follow in channel order.
- Saturation (PEND_W=2): 5 COIN_REQ2 pulses while meter 2 is held ON.
  - PEND2 tops at 3 after the first count is consumed.
  - OVF=10.
  - Exactly 4 ON writes reach ADDR=001.
- Lockout toggle: LOCK_REQ1 goes 0→1 then back to 0 during that write's STROBE.
  - Two writes to ADDR=010, data 1 then data 0.
  - No counter writes occur.
- Reset mid-strobe: nRESET low during B_STROBE with PEND1=2.
  - nCOUNTOUT=1 next cycle; PEND1=0; BUSY=0.
  - No further writes until a new request arrives.
